// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port round-robin arbiter with bounded burst lock for the global-buffer SRAM
module sram_port_arbiter #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_wen,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wen,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);

    localparam logic [1:0] S_FREE  = 2'd0;
    localparam logic [1:0] S_OWN_A = 2'd1;
    localparam logic [1:0] S_OWN_B = 2'd2;
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST - 1);

    logic [1:0]        state_q, state_d;
    logic              rr_last_q, rr_last_d;   // 1 = B was granted last
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic [1:0]        rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              grant_a, grant_b;

    // An owner keeps the port unless the other side has waited out the burst limit.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (state_q == S_OWN_A && a_req) begin
                if (b_req && burst_cnt_q == BURST_LIMIT) grant_b = 1'b1;
                else                                     grant_a = 1'b1;
            end else if (state_q == S_OWN_B && b_req) begin
                if (a_req && burst_cnt_q == BURST_LIMIT) grant_a = 1'b1;
                else                                     grant_b = 1'b1;
            end else if (a_req && b_req) begin
                grant_a = rr_last_q;
                grant_b = !rr_last_q;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    always_comb begin
        state_d     = S_FREE;
        rr_last_d   = rr_last_q;
        burst_cnt_d = burst_cnt_q;
        addr_d      = addr_q;
        if (grant_a) begin
            state_d   = a_lock ? S_OWN_A : S_FREE;
            rr_last_d = 1'b0;
            addr_d    = a_addr;
            if (state_q != S_OWN_A)                   burst_cnt_d = 8'd0;
            else if (b_req && burst_cnt_q != 8'hFF)   burst_cnt_d = burst_cnt_q + 8'd1;
        end else if (grant_b) begin
            state_d   = b_lock ? S_OWN_B : S_FREE;
            rr_last_d = 1'b1;
            addr_d    = b_addr;
            if (state_q != S_OWN_B)                   burst_cnt_d = 8'd0;
            else if (a_req && burst_cnt_q != 8'hFF)   burst_cnt_d = burst_cnt_q + 8'd1;
        end
        rd_owner_d = {grant_b & ~b_wen, grant_a & ~a_wen};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FREE;
            rr_last_q   <= 1'b1;
            burst_cnt_q <= 8'd0;
            rd_owner_q  <= 2'b00;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            burst_cnt_q <= burst_cnt_d;
            rd_owner_q  <= rd_owner_d;
            addr_q      <= addr_d;
        end
    end

    // Idle cycles re-present the last address so the SRAM sees a stable, ignored read.
    always_comb begin
        sram_wen  = 1'b0;
        sram_addr = addr_q;
        sram_di   = '0;
        if (grant_a) begin
            sram_wen  = a_wen;
            sram_addr = a_addr;
            sram_di   = a_wdata;
        end else if (grant_b) begin
            sram_wen  = b_wen;
            sram_addr = b_addr;
            sram_di   = b_wdata;
        end
    end

    assign a_gnt    = grant_a;
    assign b_gnt    = grant_b;
    assign a_rvalid = rd_owner_q[0];
    assign b_rvalid = rd_owner_q[1];
    assign a_rdata  = sram_do;
    assign b_rdata  = sram_do;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port global-buffer SRAM between two requesters.
- Port A is the host/DMA loader: it writes weights and activations and reads results back.
- Port B is the systolic-array feeder and drain.
- Arbitration is round-robin with an optional bounded burst lock.
- Each port uses a req/gnt handshake. Read data is routed back to the issuing port with a 1-cycle SRAM read latency.

Parameters:
- DATA_W, 128, SRAM word width (matches WORD_SIZE).
- ADDR_W, 10, SRAM word address width (matches WORD_ADDR_BITS).
- MAX_BURST, 8, maximum consecutive grants to a locked owner while the other port is requesting; valid range 1..255.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- a_req  in  1  port A access request for this cycle.
- a_wen  in  1  1 = write, 0 = read.
- a_lock  in  1  request to keep ownership on following cycles (burst).
- a_addr  in  ADDR_W  word address.
- a_wdata  in  DATA_W  write data.
- a_gnt  out  1  access accepted this cycle (combinational).
- a_rvalid  out  1  read data for port A valid this cycle.
- a_rdata  out  DATA_W  read data (equals sram_do).
- b_req, b_wen, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical meanings for port B.
- sram_wen  out  1  to SRAM wen.
- sram_addr  out  ADDR_W  to SRAM addr.
- sram_di  out  DATA_W  to SRAM DI.
- sram_do  in  DATA_W  from SRAM DO.

Behaviour:
- State machine: FREE, OWN_A, OWN_B. Registers: rr_last (last granted port), burst_cnt (8 bit), rd_owner_q (2 bit, one-hot A/B, 0 = none).
- Reset (async, rst=1):
  - State FREE; rr_last = B, so A wins first; burst_cnt = 0; rd_owner_q = 0.
  - a_rvalid = b_rvalid = 0.
  - With no grant, sram_wen = 0, sram_addr = 0, sram_di = 0.
- FREE:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to rr_last is granted.
- OWN_x: x is granted whenever x_req=1.
  - If x_req=0, ownership is dropped and FREE arbitration applies in the same cycle.
  - If the other port requests and burst_cnt == MAX_BURST-1, the other port is granted instead and ownership is dropped.
- Transitions on a granted cycle with port x:
  - Next state OWN_x if x_lock=1, else FREE.
  - rr_last <= x.
  - burst_cnt <= 0 on entry to OWN_x from another state, else burst_cnt+1.
  - burst_cnt only counts while the other port requests. If the other port is idle it holds (saturating, no wrap).
- Grant outputs: at most one of a_gnt/b_gnt is high per cycle. A grant is never asserted without the matching req.
- SRAM drive (combinational mux of the granted port):
  - sram_wen = x_wen, sram_addr = x_addr, sram_di = x_wdata.
  - No grant: sram_wen = 0 and sram_addr holds the last granted address (registered). The SRAM performs a harmless read that is ignored.
- Read return:
  - A granted read in cycle N sets rd_owner_q; x_rvalid = 1 in cycle N+1 with x_rdata = sram_do.
  - Writes never raise rvalid.
  - Back-to-back reads give rvalid every cycle.
  - a_rdata and b_rdata both carry sram_do; only rvalid qualifies them.
- Write-then-read to the same address in consecutive cycles returns the new data, because the SRAM write completes at posedge N.
- Reset asserted mid-burst or with a read in flight:
  - The pending rvalid is dropped; the state returns to FREE.
  - No grant is issued while rst=1.

Test Plan:
- After reset, a_req=1 read addr 5 and b_req=1 read addr 9 in the same cycle -> a_gnt=1, b_gnt=0. Next cycle b_gnt=1. a_rvalid follows one cycle after A's grant with the addr 5 data; b_rvalid follows one cycle after B's grant with the addr 9 data.
- Port A writes 0xDEAD to addr 3, then port B reads addr 3 next cycle -> b_rvalid one cycle after B's grant, b_rdata=0xDEAD, a_rvalid stays 0.
- Port A holds a_lock=1 and a_req=1 for 20 cycles while b_req=1 continuously, MAX_BURST=8 -> A is granted 8 consecutive cycles, then B gets 1 grant, then A resumes. This repeats with no cycle where both gnt are high.
- Port A locked and B idle for 300 cycles -> A is granted every cycle and burst_cnt does not wrap. When B then requests, B is granted within MAX_BURST cycles.
- Alternating reads from A and B every cycle -> the rvalid sequence matches the grant sequence delayed by 1 and is never misrouted.
- rst pulsed high during an A read grant -> a_rvalid=0 next cycle, sram_wen=0, state FREE. The first post-reset contention is won by A.
